// File: rtl/vector_store_sequencer.sv
// Serialises a vector register into scalar bus writes for unit-stride and strided stores.
// One element per cycle (active or skipped), honouring vstart, vl, the v0 mask and SEW.
module vector_store_sequencer #(
  parameter int unsigned VLENB  = 16,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [8*VLENB-1:0]  req_data,
  input  logic [ADDR_W-1:0]   req_base,
  input  logic [31:0]         req_stride,
  input  logic [1:0]          req_mop,
  input  logic [2:0]          req_sew,
  input  logic [4:0]          req_vl,
  input  logic [4:0]          req_vstart,
  input  logic                req_vm,
  input  logic [VLENB-1:0]    req_mask,
  output logic                dmem_wen,
  output logic [ADDR_W-1:0]   dmem_addr,
  output logic [31:0]         dmem_wdata,
  output logic [3:0]          dmem_byte_en,
  input  logic                dmem_busy,
  output logic                done,
  output logic                exception,
  output logic [1:0]          exc_cause,
  output logic [4:0]          fault_idx
);

  localparam logic [1:0] MOP_UNIT     = 2'b00;
  localparam logic [1:0] MOP_STRIDED  = 2'b10;
  localparam logic [2:0] SEW32        = 3'b010;
  localparam logic [1:0] CAUSE_NONE   = 2'b00;
  localparam logic [1:0] CAUSE_ILL    = 2'b01;
  localparam logic [1:0] CAUSE_MISAL  = 2'b10;
  localparam int unsigned IdxW        = $clog2(VLENB);

  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

  state_e              state_q, state_d;
  logic [8*VLENB-1:0]  data_q;
  logic [ADDR_W-1:0]   step_q;
  logic [1:0]          sew_q;
  logic [4:0]          vl_q;
  logic                vm_q;
  logic [VLENB-1:0]    mask_q;
  logic [4:0]          idx_q, idx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          cause_q, cause_d;
  logic [4:0]          fault_q, fault_d;
  logic                accept;

  // Request decode, only meaningful in StIdle.
  logic [31:0]         vl_lim;
  logic                illegal;
  logic [ADDR_W-1:0]   req_step;
  logic [ADDR_W-1:0]   start_addr;

  always_comb begin
    vl_lim     = VLENB >> req_sew;
    illegal    = ((req_mop != MOP_UNIT) && (req_mop != MOP_STRIDED)) ||
                 (req_sew > SEW32) || (32'(req_vl) > vl_lim);
    req_step   = (req_mop == MOP_STRIDED) ? ADDR_W'(req_stride) : ADDR_W'(32'd1 << req_sew);
    start_addr = req_base + req_step * ADDR_W'(req_vstart);
  end

  // Element datapath from registered state only.
  logic [1:0]  lane;
  logic [31:0] bit_off;
  logic [31:0] elem_mask;
  logic [31:0] elem;
  logic [3:0]  be_base;
  logic        misaligned;
  logic        active;
  logic        wr;

  always_comb begin
    lane    = addr_q[1:0];
    bit_off = (32'(idx_q) << sew_q) << 3;
    unique case (sew_q)
      2'd0: begin
        elem_mask  = 32'h0000_00ff;
        be_base    = 4'b0001;
        misaligned = 1'b0;
      end
      2'd1: begin
        elem_mask  = 32'h0000_ffff;
        be_base    = 4'b0011;
        misaligned = addr_q[0];
      end
      default: begin
        elem_mask  = 32'hffff_ffff;
        be_base    = 4'b1111;
        misaligned = (addr_q[1:0] != 2'b00);
      end
    endcase
    elem   = 32'(data_q >> bit_off) & elem_mask;
    active = vm_q | mask_q[idx_q[IdxW-1:0]];
    wr     = (state_q == StRun) && active && !misaligned;
  end

  always_comb begin
    dmem_wen     = wr;
    dmem_addr    = wr ? addr_q : '0;
    dmem_wdata   = wr ? (elem << {lane, 3'b000}) : '0;
    dmem_byte_en = wr ? (be_base << lane) : '0;
    req_ready    = (state_q == StIdle);
    done         = (state_q == StFinish) && (cause_q == CAUSE_NONE);
    exception    = (state_q == StFinish) && (cause_q != CAUSE_NONE);
    exc_cause    = cause_q;
    fault_idx    = fault_q;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    cause_d = cause_q;
    fault_d = fault_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          accept  = 1'b1;
          idx_d   = req_vstart;
          addr_d  = start_addr;
          cause_d = CAUSE_NONE;
          fault_d = '0;
          if (illegal) begin
            state_d = StFinish;
            cause_d = CAUSE_ILL;
            fault_d = req_vstart;
          end else if (req_vstart >= req_vl) begin
            state_d = StFinish;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (active && misaligned) begin
          state_d = StFinish;
          cause_d = CAUSE_MISAL;
          fault_d = idx_q;
        end else if (!active || !dmem_busy) begin
          idx_d  = idx_q + 5'd1;
          addr_d = addr_q + step_q;
          if ((idx_q + 5'd1) == vl_q) begin
            state_d = StFinish;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      idx_q   <= '0;
      addr_q  <= '0;
      cause_q <= '0;
      fault_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      cause_q <= cause_d;
      fault_q <= fault_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_q <= '0;
      step_q <= '0;
      sew_q  <= '0;
      vl_q   <= '0;
      vm_q   <= 1'b0;
      mask_q <= '0;
    end else if (accept) begin
      data_q <= req_data;
      step_q <= req_step;
      sew_q  <= req_sew[1:0];
      vl_q   <= req_vl;
      vm_q   <= req_vm;
      mask_q <= req_mask;
    end
  end

endmodule

// File: tb/tb_vector_store_sequencer.sv
// Scoreboard bench for vector_store_sequencer: directed requests push expected writes and
// completions with their cycle; a negedge monitor pops and compares.
module tb_vector_store_sequencer;

  logic         CLK;
  logic         RST;
  logic         req_valid;
  logic         req_ready;
  logic [127:0] req_data;
  logic [31:0]  req_base;
  logic [31:0]  req_stride;
  logic [1:0]   req_mop;
  logic [2:0]   req_sew;
  logic [4:0]   req_vl;
  logic [4:0]   req_vstart;
  logic         req_vm;
  logic [15:0]  req_mask;
  logic         dmem_wen;
  logic [31:0]  dmem_addr;
  logic [31:0]  dmem_wdata;
  logic [3:0]   dmem_byte_en;
  logic         dmem_busy;
  logic         done;
  logic         exception;
  logic [1:0]   exc_cause;
  logic [4:0]   fault_idx;

  vector_store_sequencer #(.VLENB(16), .ADDR_W(32)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_data     (req_data),
    .req_base     (req_base),
    .req_stride   (req_stride),
    .req_mop      (req_mop),
    .req_sew      (req_sew),
    .req_vl       (req_vl),
    .req_vstart   (req_vstart),
    .req_vm       (req_vm),
    .req_mask     (req_mask),
    .dmem_wen     (dmem_wen),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_byte_en (dmem_byte_en),
    .dmem_busy    (dmem_busy),
    .done         (done),
    .exception    (exception),
    .exc_cause    (exc_cause),
    .fault_idx    (fault_idx)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int          cyc;
  } wr_t;

  typedef struct {
    bit          exc;
    logic [1:0]  cause;
    logic [4:0]  idx;
    int          cyc;
  } cmp_t;

  wr_t  wq[$];
  cmp_t cq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   t0      = 0;
  bit   mon_en  = 1'b0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // k is the 1-based cycle after the accept edge.
  task automatic push_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                        input int k);
    wr_t e;
    e.addr = a; e.data = d; e.be = be; e.cyc = t0 + k - 1;
    wq.push_back(e);
  endtask

  task automatic push_c(input bit exc, input logic [1:0] cause, input logic [4:0] idx,
                        input int k);
    cmp_t e;
    e.exc = exc; e.cause = cause; e.idx = idx; e.cyc = t0 + k - 1;
    cq.push_back(e);
  endtask

  task automatic issue(input logic [1:0] mop, input logic [2:0] sew, input logic [4:0] vl,
                       input logic [4:0] vstart, input logic vm, input logic [15:0] mask,
                       input logic [31:0] base, input logic [31:0] stride,
                       input logic [127:0] data);
    @(negedge CLK);
    req_mop = mop; req_sew = sew; req_vl = vl; req_vstart = vstart; req_vm = vm;
    req_mask = mask; req_base = base; req_stride = stride; req_data = data;
    req_valid = 1'b1;
    @(posedge CLK);
    #1;
    t0 = cyc;
    req_valid = 1'b0;
    req_data = '1;
    req_base = '1;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (wq.size() == 0 && cq.size() == 0 && req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      fail("timeout waiting for completion");
      wq.delete();
      cq.delete();
    end
  endtask

  always @(negedge CLK) begin
    if (mon_en && !RST) begin
      if (dmem_wen) begin
        if (wq.size() == 0) begin
          fail("unexpected_write");
        end else begin
          wr_t e;
          e = wq[0];
          chk("wr_addr", 64'(dmem_addr), 64'(e.addr));
          chk("wr_data", 64'(dmem_wdata), 64'(e.data));
          chk("wr_be", 64'(dmem_byte_en), 64'(e.be));
          if (!dmem_busy) begin
            chk("wr_cycle", 64'(cyc), 64'(e.cyc));
            void'(wq.pop_front());
          end
        end
      end
      if (done || exception) begin
        if (cq.size() == 0) begin
          fail("unexpected_completion");
        end else begin
          cmp_t c;
          c = cq.pop_front();
          chk("done", 64'(done), 64'(!c.exc));
          chk("exception", 64'(exception), 64'(c.exc));
          if (c.exc) begin
            chk("exc_cause", 64'(exc_cause), 64'(c.cause));
            chk("fault_idx", 64'(fault_idx), 64'(c.idx));
          end
          chk("cmp_cycle", 64'(cyc), 64'(c.cyc));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    req_valid = 1'b0; req_data = '0; req_base = '0; req_stride = '0; req_mop = '0;
    req_sew = '0; req_vl = '0; req_vstart = '0; req_vm = 1'b1; req_mask = '0;
    dmem_busy = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_wen", 64'(dmem_wen), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_exc", 64'(exception), 64'd0);
    chk("rst_cause", 64'(exc_cause), 64'd0);
    chk("rst_fidx", 64'(fault_idx), 64'd0);
    chk("rst_addr", 64'(dmem_addr), 64'd0);
    chk("rst_wdata", 64'(dmem_wdata), 64'd0);
    chk("rst_be", 64'(dmem_byte_en), 64'd0);
    RST = 1'b0;
    mon_en = 1'b1;
    @(negedge CLK);

    // Unit-stride SEW32, vl=4
    issue(2'b00, 3'd2, 5'd4, 5'd0, 1'b1, 16'h0, 32'h100, 32'h0,
          128'h04040404_03030303_02020202_01010101);
    push_w(32'h100, 32'h01010101, 4'b1111, 1);
    push_w(32'h104, 32'h02020202, 4'b1111, 2);
    push_w(32'h108, 32'h03030303, 4'b1111, 3);
    push_w(32'h10C, 32'h04040404, 4'b1111, 4);
    push_c(1'b0, 2'b00, 5'd0, 5);
    wait_idle();

    // Strided SEW8, stride 5, unaligned lanes
    issue(2'b10, 3'd0, 5'd3, 5'd0, 1'b1, 16'h0, 32'h203, 32'd5, 128'hCCBBAA);
    push_w(32'h203, 32'hAA000000, 4'b1000, 1);
    push_w(32'h208, 32'h000000BB, 4'b0001, 2);
    push_w(32'h20D, 32'h0000CC00, 4'b0010, 3);
    push_c(1'b0, 2'b00, 5'd0, 4);
    wait_idle();

    // Masked unit-stride SEW16, mask 1010
    issue(2'b00, 3'd1, 5'd4, 5'd0, 1'b0, 16'b1010, 32'h40, 32'h0,
          128'h4444_3333_2222_1111);
    push_w(32'h42, 32'h22220000, 4'b1100, 2);
    push_w(32'h46, 32'h44440000, 4'b1100, 4);
    push_c(1'b0, 2'b00, 5'd0, 5);
    wait_idle();

    // Bus busy for 3 cycles on the first write
    dmem_busy = 1'b1;
    issue(2'b00, 3'd2, 5'd2, 5'd0, 1'b1, 16'h0, 32'h300, 32'h0, 128'h55667788_11223344);
    push_w(32'h300, 32'h11223344, 4'b1111, 4);
    push_w(32'h304, 32'h55667788, 4'b1111, 5);
    push_c(1'b0, 2'b00, 5'd0, 6);
    repeat (3) @(posedge CLK);
    #1 dmem_busy = 1'b0;
    wait_idle();

    // Misaligned SEW32
    issue(2'b00, 3'd2, 5'd2, 5'd0, 1'b1, 16'h0, 32'h102, 32'h0, 128'h1);
    push_c(1'b1, 2'b10, 5'd0, 2);
    wait_idle();

    // Illegal: indexed mop, fault_idx reports vstart
    issue(2'b01, 3'd2, 5'd4, 5'd3, 1'b1, 16'h0, 32'h100, 32'h0, 128'h1);
    push_c(1'b1, 2'b01, 5'd3, 1);
    wait_idle();

    // Illegal: SEW64
    issue(2'b00, 3'd3, 5'd1, 5'd0, 1'b1, 16'h0, 32'h100, 32'h0, 128'h1);
    push_c(1'b1, 2'b01, 5'd0, 1);
    wait_idle();

    // Illegal: vl=9 at SEW16
    issue(2'b00, 3'd1, 5'd9, 5'd0, 1'b1, 16'h0, 32'h100, 32'h0, 128'h1);
    push_c(1'b1, 2'b01, 5'd0, 1);
    wait_idle();

    // vstart >= vl: immediate success
    issue(2'b00, 3'd2, 5'd2, 5'd2, 1'b1, 16'h0, 32'h100, 32'h0, 128'h1);
    push_c(1'b0, 2'b00, 5'd0, 1);
    wait_idle();

    // Unit-stride SEW16 from vstart=1
    issue(2'b00, 3'd1, 5'd3, 5'd1, 1'b1, 16'h0, 32'h80, 32'h0, 128'hC2C2_B1B1_A0A0);
    push_w(32'h82, 32'hB1B10000, 4'b1100, 1);
    push_w(32'h84, 32'h0000C2C2, 4'b0011, 2);
    push_c(1'b0, 2'b00, 5'd0, 3);
    wait_idle();

    // Strided SEW16 with stride 0xFFFFFFFC (wraps to -4)
    issue(2'b10, 3'd1, 5'd2, 5'd0, 1'b1, 16'h0, 32'h10, 32'hFFFF_FFFC, 128'h5678_1234);
    push_w(32'h10, 32'h00001234, 4'b0011, 1);
    push_w(32'h0C, 32'h00005678, 4'b0011, 2);
    push_c(1'b0, 2'b00, 5'd0, 3);
    wait_idle();

    // Reset during a stalled write
    mon_en = 1'b0;
    dmem_busy = 1'b1;
    issue(2'b00, 3'd2, 5'd4, 5'd0, 1'b1, 16'h0, 32'h500, 32'h0, 128'h1);
    @(negedge CLK);
    chk("pre_rst_wen", 64'(dmem_wen), 64'd1);
    chk("pre_rst_addr", 64'(dmem_addr), 64'h500);
    #2 RST = 1'b1;
    #1;
    chk("async_rst_wen", 64'(dmem_wen), 64'd0);
    chk("async_rst_ready", 64'(req_ready), 64'd1);
    chk("async_rst_done", 64'(done), 64'd0);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    dmem_busy = 1'b0;
    @(negedge CLK);
    chk("post_rst_ready", 64'(req_ready), 64'd1);
    chk("post_rst_wen", 64'(dmem_wen), 64'd0);
    chk("post_rst_done", 64'(done), 64'd0);
    mon_en = 1'b1;

    chk("wq_empty", 64'(wq.size()), 64'd0);
    chk("cq_empty", 64'(cq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_store_sequencer.md
# vector_store_sequencer

Serialises one vector register's worth of data into scalar data-memory write transactions for vector unit-stride and strided stores (`mop_t` MOP_UNIT / MOP_STRIDED). It sits between the vector store unit's issue logic and the core's generic data bus, in the write direction. It emits one bus write per active element, honouring `vstart`, `vl`, the `v0` mask and SEW, and reports completion or an exception back to issue.

## Interface
Parameters:
- `VLENB`, 16, vector register size in bytes; one mask bit per byte-element.
- `ADDR_W`, 32, bus address width.

Ports (reset is asynchronous, active-high):
- `CLK`  in  1  clock.
- `RST`  in  1  asynchronous active-high reset.
- `req_valid`  in  1  store request present.
- `req_ready`  out  1  high in IDLE.
- `req_data`  in  8*VLENB  source vreg (`vreg_t`), byte 0 = element 0 LSB.
- `req_base`  in  ADDR_W  rs1 base address.
- `req_stride`  in  32  rs2 byte stride; used only for MOP_STRIDED.
- `req_mop`  in  2  `mop_t`.
- `req_sew`  in  3  `sew_t`; element size eb = 1<<sew bytes.
- `req_vl`  in  5  element count, 0..VLENB.
- `req_vstart`  in  5  first element index.
- `req_vm`  in  1  1 = unmasked.
- `req_mask`  in  VLENB  v0 bits, bit i = element i.
- `dmem_wen`  out  1  write request.
- `dmem_addr`  out  ADDR_W  byte address.
- `dmem_wdata`  out  32  lane-aligned write data.
- `dmem_byte_en`  out  4  byte lanes.
- `dmem_busy`  in  1  bus stall; a write completes in a cycle with `dmem_wen`=1 and `dmem_busy`=0.
- `done`  out  1  one-cycle success pulse.
- `exception`  out  1  one-cycle fault pulse.
- `exc_cause`  out  2  01 illegal, 10 misaligned; held until next accept.
- `fault_idx`  out  5  faulting element index; held until next accept.

## Operation
- States: IDLE, RUN, FINISH.
- Accept on `req_valid & req_ready` in IDLE. All request fields are registered at accept.
- Illegal conditions at accept: mop ∉ {UNIT, STRIDED}, sew > SEW32, or vl > VLENB>>sew.
  - Illegal → FINISH with `exc_cause`=01, `fault_idx`=vstart.
- Else if vstart ≥ vl → FINISH with success.
- Else → RUN with idx=vstart and addr = base + vstart*S (mod 2^ADDR_W).
  - S = stride for STRIDED, eb for UNIT.
- RUN, element idx active (vm=1 or mask[idx]=1):
  - Misaligned if addr mod eb ≠ 0 → FINISH with cause 10, `fault_idx`=idx, no `dmem_wen`.
  - Else `dmem_wen`=1, `dmem_addr`=addr.
  - `dmem_wdata` = element bytes `req_data[idx*eb*8 +: eb*8]` shifted left by 8*addr[1:0]; all other lanes 0.
  - `dmem_byte_en` = ((1<<eb)-1) << addr[1:0].
  - On completion: idx+1, addr+S.
- RUN, element inactive: no bus activity; idx+1, addr+S in one cycle.
- When the new idx equals vl → FINISH; otherwise stay in RUN.
- FINISH: `done`=1 (success) or `exception`=1; `req_ready`=0; next state IDLE.
- Address arithmetic wraps modulo 2^ADDR_W; stride is treated as unsigned.

## Timing
- Reset: IDLE, `req_ready`=1; `dmem_wen`, `done`, `exception` = 0; `exc_cause`=0, `fault_idx`=0, `dmem_addr`/`wdata`/`byte_en`=0.
- `RST` mid-operation: immediate return to IDLE, `dmem_wen` drops asynchronously, no `done` pulse.
- Accept at cycle T:
  - First bus write, first skip, or first misaligned detection occurs at T+1.
  - Illegal requests and vstart ≥ vl reach FINISH at T+1.
- Zero-wait bus: one element per cycle, active or skipped. n elements from vstart → activity T+1..T+n, `done` at T+n+1, `req_ready` at T+n+2.
- While `dmem_busy`=1: `dmem_addr`, `dmem_wdata` and `dmem_byte_en` are held stable and `dmem_wen` stays high.
- `dmem_wen`, `dmem_addr`, `dmem_wdata` and `dmem_byte_en` are combinational from registered state; there is no dependency on `req_*` after accept.

## Test plan
- Unit-stride SEW32, vl=4, vm=1, base 0x100, element i = 0x(i+1) repeated; busy=0 → writes to 0x100, 0x104, 0x108, 0x10C with byte_en 1111 at T+1..T+4; `done` at T+5.
- Strided SEW8, stride 5, base 0x203, vl=3, bytes AA/BB/CC:
  - 0x203: wdata AA000000, be 1000.
  - 0x208: wdata 000000BB, be 0001.
  - 0x20D: wdata 0000CC00, be 0010.
- Masked unit-stride SEW16, vl=4, vm=0, mask=0b1010, base 0x40 → only 0x42 and 0x46 written (be 1100 each); skips at T+1 and T+3; `done` at T+5.
- `dmem_busy` high for 3 cycles on the first write → addr/data/be held for 4 cycles; second write follows on the next cycle; `done` is delayed by 3 cycles.
- Faults:
  - SEW32 with base 0x102 → `exception` at T+2, cause 10, `fault_idx`=0, no `dmem_wen`.
  - mop=MOP_UINDEXED, sew=SEW64, or vl=9 at SEW16 → `exception` at T+1, cause 01.
- vstart=2, vl=2 → `done` at T+1 with no writes.
- `RST` asserted during a busy write → `dmem_wen`=0 immediately; `req_ready`=1 after reset.
